// File: rtl/apb_arbiter.sv
// Two-to-one APB arbiter: latches the granted requester's transfer, replays it to a
// single completer as setup/access, and returns the registered response to the owner.
module apb_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_psel,
  input  logic        m0_penable,
  input  logic [31:0] m0_paddr,
  input  logic        m0_pwrite,
  input  logic [31:0] m0_pwdata,
  input  logic [3:0]  m0_pwstrb,
  output logic        m0_pready,
  output logic [31:0] m0_prdata,
  output logic        m0_pslverr,
  input  logic        m1_psel,
  input  logic        m1_penable,
  input  logic [31:0] m1_paddr,
  input  logic        m1_pwrite,
  input  logic [31:0] m1_pwdata,
  input  logic [3:0]  m1_pwstrb,
  output logic        m1_pready,
  output logic [31:0] m1_prdata,
  output logic        m1_pslverr,
  output logic        s_psel,
  output logic        s_penable,
  output logic [31:0] s_paddr,
  output logic        s_pwrite,
  output logic [31:0] s_pwdata,
  output logic [3:0]  s_pwstrb,
  input  logic        s_pready,
  input  logic [31:0] s_prdata,
  input  logic        s_pslverr
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SETUP    = 2'd1;
  localparam logic [1:0] ST_ACCESS   = 2'd2;
  localparam logic [1:0] ST_COMPLETE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        lg_q, lg_d;
  logic        s_psel_q, s_psel_d;
  logic        s_penable_q, s_penable_d;
  logic [31:0] s_paddr_q, s_paddr_d;
  logic        s_pwrite_q, s_pwrite_d;
  logic [31:0] s_pwdata_q, s_pwdata_d;
  logic [3:0]  s_pwstrb_q, s_pwstrb_d;
  logic        m0_pready_q, m0_pready_d;
  logic [31:0] m0_prdata_q, m0_prdata_d;
  logic        m0_pslverr_q, m0_pslverr_d;
  logic        m1_pready_q, m1_pready_d;
  logic [31:0] m1_prdata_q, m1_prdata_d;
  logic        m1_pslverr_q, m1_pslverr_d;
  logic        grant;

  // Enable is deliberately not looked at: psel alone marks a pending request.
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d      = state_q;
    owner_d      = owner_q;
    lg_d         = lg_q;
    s_psel_d     = s_psel_q;
    s_penable_d  = s_penable_q;
    s_paddr_d    = s_paddr_q;
    s_pwrite_d   = s_pwrite_q;
    s_pwdata_d   = s_pwdata_q;
    s_pwstrb_d   = s_pwstrb_q;
    m0_pready_d  = m0_pready_q;
    m0_prdata_d  = m0_prdata_q;
    m0_pslverr_d = m0_pslverr_q;
    m1_pready_d  = m1_pready_q;
    m1_prdata_d  = m1_prdata_q;
    m1_pslverr_d = m1_pslverr_q;
    grant        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m0_psel || m1_psel) begin
          // On contention, round robin hands the grant to whoever did not win last.
          if (m0_psel && m1_psel) grant = ROUND_ROBIN ? ~lg_q : 1'b0;
          else                    grant = m1_psel;
          owner_d     = grant;
          lg_d        = grant;
          s_paddr_d   = grant ? m1_paddr  : m0_paddr;
          s_pwrite_d  = grant ? m1_pwrite : m0_pwrite;
          s_pwdata_d  = grant ? m1_pwdata : m0_pwdata;
          s_pwstrb_d  = grant ? m1_pwstrb : m0_pwstrb;
          s_psel_d    = 1'b1;
          s_penable_d = 1'b0;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        s_penable_d = 1'b1;
        state_d     = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (s_pready) begin
          s_psel_d    = 1'b0;
          s_penable_d = 1'b0;
          if (owner_q) begin
            m1_pready_d  = 1'b1;
            m1_prdata_d  = s_prdata;
            m1_pslverr_d = s_pslverr;
          end else begin
            m0_pready_d  = 1'b1;
            m0_prdata_d  = s_prdata;
            m0_pslverr_d = s_pslverr;
          end
          state_d = ST_COMPLETE;
        end
      end
      default: begin
        // The owner still holds psel for the finished transfer; it is not re-sampled here.
        m0_pready_d  = 1'b0;
        m0_prdata_d  = 32'd0;
        m0_pslverr_d = 1'b0;
        m1_pready_d  = 1'b0;
        m1_prdata_d  = 32'd0;
        m1_pslverr_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      lg_q         <= 1'b1;
      s_psel_q     <= 1'b0;
      s_penable_q  <= 1'b0;
      s_paddr_q    <= 32'd0;
      s_pwrite_q   <= 1'b0;
      s_pwdata_q   <= 32'd0;
      s_pwstrb_q   <= 4'd0;
      m0_pready_q  <= 1'b0;
      m0_prdata_q  <= 32'd0;
      m0_pslverr_q <= 1'b0;
      m1_pready_q  <= 1'b0;
      m1_prdata_q  <= 32'd0;
      m1_pslverr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lg_q         <= lg_d;
      s_psel_q     <= s_psel_d;
      s_penable_q  <= s_penable_d;
      s_paddr_q    <= s_paddr_d;
      s_pwrite_q   <= s_pwrite_d;
      s_pwdata_q   <= s_pwdata_d;
      s_pwstrb_q   <= s_pwstrb_d;
      m0_pready_q  <= m0_pready_d;
      m0_prdata_q  <= m0_prdata_d;
      m0_pslverr_q <= m0_pslverr_d;
      m1_pready_q  <= m1_pready_d;
      m1_prdata_q  <= m1_prdata_d;
      m1_pslverr_q <= m1_pslverr_d;
    end
  end

  assign s_psel     = s_psel_q;
  assign s_penable  = s_penable_q;
  assign s_paddr    = s_paddr_q;
  assign s_pwrite   = s_pwrite_q;
  assign s_pwdata   = s_pwdata_q;
  assign s_pwstrb   = s_pwstrb_q;
  assign m0_pready  = m0_pready_q;
  assign m0_prdata  = m0_prdata_q;
  assign m0_pslverr = m0_pslverr_q;
  assign m1_pready  = m1_pready_q;
  assign m1_prdata  = m1_prdata_q;
  assign m1_pslverr = m1_pslverr_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: a round-robin instance driving a small RAM model,
// plus a fixed-priority instance sharing the requester inputs for contention order.
module tb_apb_arbiter;

  logic        clk, rst_n;
  logic        m0_psel, m0_penable, m0_pwrite, m1_psel, m1_penable, m1_pwrite;
  logic [31:0] m0_paddr, m0_pwdata, m1_paddr, m1_pwdata;
  logic [3:0]  m0_pwstrb, m1_pwstrb;
  logic        m0_pready, m0_pslverr, m1_pready, m1_pslverr;
  logic [31:0] m0_prdata, m1_prdata;
  logic        s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
  logic [31:0] s_paddr, s_pwdata, s_prdata;
  logic [3:0]  s_pwstrb;

  logic        fp_m0_pready, fp_m0_pslverr, fp_m1_pready, fp_m1_pslverr;
  logic [31:0] fp_m0_prdata, fp_m1_prdata;
  logic        fp_s_psel, fp_s_penable, fp_s_pwrite;
  logic [31:0] fp_s_paddr, fp_s_pwdata;
  logic [3:0]  fp_s_pwstrb;
  logic        fp_s_pready, fp_s_pslverr;
  logic [31:0] fp_s_prdata;

  int          n_checks = 0;
  int          n_errors = 0;
  int          wait_cycles = 0;
  int          acc_cnt;
  logic        err_inject = 1'b0;
  bit          preload;
  logic [31:0] mem [256];

  apb_arbiter #(.ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_paddr(m0_paddr), .m0_pwrite(m0_pwrite),
    .m0_pwdata(m0_pwdata), .m0_pwstrb(m0_pwstrb), .m0_pready(m0_pready), .m0_prdata(m0_prdata),
    .m0_pslverr(m0_pslverr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_paddr(m1_paddr), .m1_pwrite(m1_pwrite),
    .m1_pwdata(m1_pwdata), .m1_pwstrb(m1_pwstrb), .m1_pready(m1_pready), .m1_prdata(m1_prdata),
    .m1_pslverr(m1_pslverr),
    .s_psel(s_psel), .s_penable(s_penable), .s_paddr(s_paddr), .s_pwrite(s_pwrite),
    .s_pwdata(s_pwdata), .s_pwstrb(s_pwstrb), .s_pready(s_pready), .s_prdata(s_prdata),
    .s_pslverr(s_pslverr)
  );

  apb_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_paddr(m0_paddr), .m0_pwrite(m0_pwrite),
    .m0_pwdata(m0_pwdata), .m0_pwstrb(m0_pwstrb), .m0_pready(fp_m0_pready),
    .m0_prdata(fp_m0_prdata), .m0_pslverr(fp_m0_pslverr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_paddr(m1_paddr), .m1_pwrite(m1_pwrite),
    .m1_pwdata(m1_pwdata), .m1_pwstrb(m1_pwstrb), .m1_pready(fp_m1_pready),
    .m1_prdata(fp_m1_prdata), .m1_pslverr(fp_m1_pslverr),
    .s_psel(fp_s_psel), .s_penable(fp_s_penable), .s_paddr(fp_s_paddr), .s_pwrite(fp_s_pwrite),
    .s_pwdata(fp_s_pwdata), .s_pwstrb(fp_s_pwstrb), .s_pready(fp_s_pready),
    .s_prdata(fp_s_prdata), .s_pslverr(fp_s_pslverr)
  );

  assign fp_s_pready  = 1'b1;
  assign fp_s_prdata  = 32'd0;
  assign fp_s_pslverr = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM completer: ready after wait_cycles access cycles, byte-strobed writes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                acc_cnt <= 0;
    else if (s_psel && s_penable && !s_pready) acc_cnt <= acc_cnt + 1;
    else                                       acc_cnt <= 0;
  end

  assign s_pready  = s_psel && s_penable && (acc_cnt >= wait_cycles);
  assign s_prdata  = mem[s_paddr[9:2]];
  assign s_pslverr = err_inject;

  always @(posedge clk) begin
    if (preload) begin
      mem[8'h04] <= 32'hDEAD_BEEF;
      mem[8'h40] <= 32'hAABB_CCDD;
    end else if (s_psel && s_penable && s_pready && s_pwrite) begin
      for (int b = 0; b < 4; b++)
        if (s_pwstrb[b]) mem[s_paddr[9:2]][8*b +: 8] <= s_pwdata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts at a negedge, returns at the negedge after the completion edge with psel dropped.
  task automatic xfer(input bit port, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input bit chg_addr,
                      output logic [31:0] rdata, output logic err, output int lat);
    bit done = 0;
    rdata = 32'hxxxx_xxxx;
    err   = 1'bx;
    lat   = 0;
    if (port) begin
      m1_psel = 1; m1_paddr = addr; m1_pwrite = wr; m1_pwdata = wdata; m1_pwstrb = strb;
    end else begin
      m0_psel = 1; m0_paddr = addr; m0_pwrite = wr; m0_pwdata = wdata; m0_pwstrb = strb;
    end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (port ? m1_pready : m0_pready) begin
        done  = 1;
        rdata = port ? m1_prdata : m0_prdata;
        err   = port ? m1_pslverr : m0_pslverr;
        check("other_pready", port ? m0_pready : m1_pready, 0);
      end
      if (s_psel) check("s_paddr_held", s_paddr, addr);
      if (lat == 1) begin
        check("s_pwstrb", {28'd0, s_pwstrb}, {28'd0, strb});
        if (port) m1_penable = 1; else m0_penable = 1;
        if (chg_addr) begin
          if (port) m1_paddr = 32'hFFFF_FFF0; else m0_paddr = 32'hFFFF_FFF0;
        end
      end
    end
    if (!done) check("xfer_timeout", 0, 1);
    @(negedge clk);
    m0_psel = 0; m0_penable = 0; m1_psel = 0; m1_penable = 0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [3:0]  order_rr, order_fp;
  int          cnt_rr, cnt_fp, both_cnt;

  initial begin
    m0_psel = 0; m0_penable = 0; m0_paddr = 0; m0_pwrite = 0; m0_pwdata = 0; m0_pwstrb = 0;
    m1_psel = 0; m1_penable = 0; m1_paddr = 0; m1_pwrite = 0; m1_pwdata = 0; m1_pwstrb = 0;
    preload = 1;
    do_reset();
    preload = 0;

    check("rst_s_psel", s_psel, 0);
    check("rst_s_penable", s_penable, 0);
    check("rst_s_paddr", s_paddr, 0);
    check("rst_m0_pready", m0_pready, 0);
    check("rst_m1_prdata", m1_prdata, 0);

    // Single zero-wait read by m0, stepped cycle by cycle.
    m0_psel = 1; m0_paddr = 32'h10; m0_pwrite = 0;
    @(negedge clk);
    check("rd_setup_psel", s_psel, 1);
    check("rd_setup_penable", s_penable, 0);
    check("rd_setup_paddr", s_paddr, 32'h10);
    m0_penable = 1;
    @(negedge clk);
    check("rd_access_psel", s_psel, 1);
    check("rd_access_penable", s_penable, 1);
    @(negedge clk);
    check("rd_m0_pready", m0_pready, 1);
    check("rd_m0_prdata", m0_prdata, 32'hDEAD_BEEF);
    check("rd_m1_pready", m1_pready, 0);
    check("rd_s_psel_drop", s_psel, 0);
    @(negedge clk);
    m0_psel = 0; m0_penable = 0;
    check("rd_m0_pready_clr", m0_pready, 0);
    check("rd_m0_prdata_clr", m0_prdata, 0);
    check("rd_m1_prdata", m1_prdata, 0);

    // Strobed write then readback through m1.
    xfer(1, 1, 32'h100, 32'h1234_5678, 4'b0011, 0, rd, er, lat);
    check("wr_lat", lat, 3);
    check("wr_pslverr", {31'd0, er}, 0);
    xfer(1, 0, 32'h100, 32'h0, 4'b0000, 0, rd, er, lat);
    check("rb_data", rd, 32'hAABB_5678);
    check("rb_pslverr", {31'd0, er}, 0);

    // Three completer wait states with an error response.
    wait_cycles = 3; err_inject = 1;
    xfer(0, 0, 32'h10, 32'h0, 4'b0000, 0, rd, er, lat);
    check("ws_lat", lat, 6);
    check("ws_pslverr", {31'd0, er}, 1);
    check("ws_data", rd, 32'hDEAD_BEEF);
    err_inject = 0;

    // m1 moves its address while the latched transfer waits in ACCESS.
    wait_cycles = 2;
    xfer(1, 0, 32'h100, 32'h0, 4'b0000, 1, rd, er, lat);
    check("chg_data", rd, 32'hAABB_5678);
    check("chg_lat", lat, 5);

    // Back-to-back reads by m0: no extra idle between them.
    wait_cycles = 0;
    xfer(0, 0, 32'h10, 32'h0, 4'b0000, 0, rd, er, lat);
    check("b2b0_lat", lat, 3);
    xfer(0, 0, 32'h100, 32'h0, 4'b0000, 0, rd, er, lat);
    check("b2b1_lat", lat, 3);
    check("b2b1_data", rd, 32'hAABB_5678);

    // Reset asserted while the completer stalls in ACCESS.
    wait_cycles = 10;
    m0_psel = 1; m0_paddr = 32'h10; m0_pwrite = 0;
    repeat (3) @(negedge clk);
    check("mid_in_access", {30'd0, s_psel, s_penable}, 32'd3);
    #2 rst_n = 0;
    #1;
    check("mid_rst_s_psel", s_psel, 0);
    check("mid_rst_s_penable", s_penable, 0);
    check("mid_rst_s_paddr", s_paddr, 0);
    m0_psel = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_no_pready", {30'd0, m0_pready, m1_pready}, 0);
    end
    wait_cycles = 0;
    xfer(0, 0, 32'h10, 32'h0, 4'b0000, 0, rd, er, lat);
    check("post_rst_data", rd, 32'hDEAD_BEEF);
    check("post_rst_lat", lat, 3);

    // Both requesters held high from reset: grant order on both instances.
    do_reset();
    m0_psel = 1; m0_paddr = 32'h10;  m0_pwrite = 0;
    m1_psel = 1; m1_paddr = 32'h100; m1_pwrite = 0;
    order_rr = 0; order_fp = 0; cnt_rr = 0; cnt_fp = 0; both_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (m0_pready && m1_pready) both_cnt++;
      if ((m0_pready || m1_pready) && cnt_rr < 4) begin
        order_rr[cnt_rr] = m1_pready;
        cnt_rr++;
      end
      if ((fp_m0_pready || fp_m1_pready) && cnt_fp < 4) begin
        order_fp[cnt_fp] = fp_m1_pready;
        cnt_fp++;
      end
    end
    m0_psel = 0; m1_psel = 0;
    repeat (2) @(negedge clk);
    check("rr_count", cnt_rr, 4);
    check("rr_order", {28'd0, order_rr}, 32'hA);
    check("fp_count", cnt_fp, 4);
    check("fp_order", {28'd0, order_fp}, 32'h0);
    check("both_pready", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Two-to-one APB arbiter that shares a single APB completer (the RAM) between two APB requesters: requester 0 (the core) and requester 1 (a secondary master such as a loader or debug port). It sits between the requesters and the completer in the system top. It captures the granted request, replays it downstream as a clean setup/access sequence, and returns the response to the owner. All outputs are registered.

## Interface
- ROUND_ROBIN, 1, 1: alternate grant on contention; 0: requester 0 always wins contention
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- m0_psel / m1_psel  input  1  requester select
- m0_penable / m1_penable  input  1  requester enable (ignored for arbitration)
- m0_paddr / m1_paddr  input  32  requester address
- m0_pwrite / m1_pwrite  input  1  1 = write
- m0_pwdata / m1_pwdata  input  32  write data
- m0_pwstrb / m1_pwstrb  input  4  byte strobes
- m0_pready / m1_pready  output  1  transfer complete to requester
- m0_prdata / m1_prdata  output  32  read data to requester
- m0_pslverr / m1_pslverr  output  1  error to requester
- s_psel, s_penable  output  1  completer select / enable
- s_paddr  output  32, s_pwrite  output  1, s_pwdata  output  32, s_pwstrb  output  4  completer request
- s_pready  input  1, s_prdata  input  32, s_pslverr  input  1  completer response

## Operation
- States: IDLE, SETUP, ACCESS, COMPLETE. Owner register (0/1); last-grant register lg (reset 1, so requester 0 wins first contention).
- IDLE: request = mX_psel high. None -> stay. One -> grant it. Both -> ROUND_ROBIN=1: grant !lg; ROUND_ROBIN=0: grant 0. On grant: owner<=X, lg<=X, latch paddr/pwrite/pwdata/pwstrb of X into s_* registers, s_psel<=1, s_penable<=0, go SETUP.
- SETUP: s_penable<=1, go ACCESS. s_* request fields held.
- ACCESS: hold s_* stable while s_pready=0 (unbounded wait). On s_pready=1: s_psel<=0, s_penable<=0, mOwner_pready<=1, mOwner_prdata<=s_prdata, mOwner_pslverr<=s_pslverr, go COMPLETE.
- COMPLETE: requester psel is still high (old transfer) and is NOT sampled. Clear mOwner_pready/prdata/pslverr to 0, go IDLE.
- Non-owner pready/prdata/pslverr remain 0 throughout; a waiting requester simply sees pready=0.
- Requester payload changes after grant are ignored (request is latched).
- s_paddr/s_pwrite/s_pwdata/s_pwstrb hold last values outside a transfer; only s_psel qualifies them.
- Write responses pass s_prdata through unchanged (completer's value).

## Timing
- Reset (async assert, any state): state IDLE, owner 0, lg 1, every output 0 immediately; a transfer in flight is abandoned without response.
- Requester psel sampled high in IDLE at edge T -> s_psel=1 after T; s_penable=1 after T+1; with s_pready=1 at T+2, mX_pready=1 for exactly the cycle after T+2, then 0 after T+3.
- Zero-wait completer: requester sees 2 wait states (pready on its 4th cycle counting setup). Each completer wait cycle adds one.
- Back-to-back: a requester re-asserting psel in the cycle after its pready is sampled in IDLE; minimum 4 cycles per transfer, no downstream gap beyond one IDLE cycle.
- Both requesting continuously with ROUND_ROBIN=1: grants strictly alternate 0,1,0,1.
- Exactly one requester pready pulse per granted transfer; never both in the same cycle.

## Test plan
- Single read: m0 reads 0x0000_0010, RAM holds 0xDEAD_BEEF, zero wait -> s_psel/s_penable sequence as above, m0_pready one cycle with m0_prdata=0xDEAD_BEEF, m1 outputs stay 0.
- Write then readback via m1: write 0x1234_5678, pwstrb=4'b0011 to 0x100 then read -> lower halfword updated, m1_pslverr=0.
- Contention: both psel rise same cycle after reset -> m0 served first, m1 next; with both held for 4 transfers, ROUND_ROBIN=1 gives 0,1,0,1 and ROUND_ROBIN=0 gives 0,0,0,0 (m1 starved).
- Completer wait states: s_pready held low 3 cycles -> s_* stable throughout, m0_pready after 3 extra cycles; s_pslverr=1 on completion -> m0_pslverr=1 with pready.
- Payload change after grant: m1 changes paddr while waiting in ACCESS -> s_paddr keeps the latched address.
- Reset mid-ACCESS: drop rst_n during ACCESS -> all outputs 0 same time, no pready pulse; after release m0 request served normally.
